// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel edge-detection datapath
// and the neighbouring image-read / display stages.
package sobel_pkg;

  localparam int PIX_W      = 8;
  localparam int SUM_W      = 10;
  localparam int MAG_MAX    = 255;
  localparam int CNT_W      = 14;
  localparam int IMG_WIDTH  = 128;
  localparam int IMG_HEIGHT = 96;
  localparam int LAT        = 3;

  // Per-pixel sideband that travels alongside the datapath.
  typedef struct packed {
    logic             valid;
    logic             sof;
    logic             border;
    logic [PIX_W-1:0] thr;
  } side_t;

  function automatic logic [PIX_W-1:0] sat_mag(input logic [SUM_W:0] s);
    return (s > SUM_W'(MAG_MAX)) ? PIX_W'(MAG_MAX) : s[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_absdiff.sv
// Registered absolute difference of two unsigned partial sums.
import sobel_pkg::*;

module sobel_absdiff (
  input  logic             clk,
  input  logic             rst,
  input  logic [SUM_W-1:0] a_i,
  input  logic [SUM_W-1:0] b_i,
  output logic [SUM_W-1:0] d_o
);

  logic [SUM_W-1:0] d_d;
  logic [SUM_W-1:0] d_q;

  always_comb begin
    d_d = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= '0;
    end else begin
      d_q <= d_d;
    end
  end

  assign d_o = d_q;

endmodule

// File: rtl/sobel_core.sv
// Three-stage Sobel |Gx|+|Gy| magnitude with per-frame threshold
// and per-frame edge-pixel counter.
module sobel_core #(
  parameter int CNT_W = sobel_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       pix_0,
  input  logic [7:0]       pix_1,
  input  logic [7:0]       pix_2,
  input  logic [7:0]       pix_3,
  input  logic [7:0]       pix_5,
  input  logic [7:0]       pix_6,
  input  logic [7:0]       pix_7,
  input  logic [7:0]       pix_8,
  input  logic             in_valid,
  input  logic             in_border,
  input  logic             in_sof,
  input  logic [7:0]       thresh,
  output logic [7:0]       mag,
  output logic             edge_flag,
  output logic             out_valid,
  output logic             out_sof,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid
);
  import sobel_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Stage 1: directional partial sums, index 0 = x, 1 = y.
  logic [SUM_W-1:0] pos_d [2];
  logic [SUM_W-1:0] neg_d [2];
  logic [SUM_W-1:0] pos_q [2];
  logic [SUM_W-1:0] neg_q [2];
  logic [PIX_W-1:0] thr_d, thr_q;
  side_t            side1_d, side1_q, side2_q;

  always_comb begin
    pos_d[0] = SUM_W'(pix_2) + (SUM_W'(pix_5) << 1) + SUM_W'(pix_8);
    neg_d[0] = SUM_W'(pix_0) + (SUM_W'(pix_3) << 1) + SUM_W'(pix_6);
    pos_d[1] = SUM_W'(pix_6) + (SUM_W'(pix_7) << 1) + SUM_W'(pix_8);
    neg_d[1] = SUM_W'(pix_0) + (SUM_W'(pix_1) << 1) + SUM_W'(pix_2);
  end

  // The sof pixel itself already uses the newly loaded threshold.
  always_comb begin
    thr_d = thr_q;
    if (in_valid && in_sof) begin
      thr_d = thresh;
    end
    side1_d.valid  = in_valid;
    side1_d.sof    = in_valid & in_sof;
    side1_d.border = in_border;
    side1_d.thr    = thr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      thr_q   <= '0;
      side1_q <= '0;
      side2_q <= '0;
    end else begin
      thr_q   <= thr_d;
      side1_q <= side1_d;
      side2_q <= side1_q;
    end
  end

  // Stage 2: absolute differences.
  logic [SUM_W-1:0] abs_q [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      always_ff @(posedge clk) begin
        if (rst) begin
          pos_q[gi] <= '0;
          neg_q[gi] <= '0;
        end else begin
          pos_q[gi] <= pos_d[gi];
          neg_q[gi] <= neg_d[gi];
        end
      end

      sobel_absdiff u_absdiff (
        .clk (clk),
        .rst (rst),
        .a_i (pos_q[gi]),
        .b_i (neg_q[gi]),
        .d_o (abs_q[gi])
      );
    end
  endgenerate

  // Stage 3: magnitude, threshold and edge counting.
  logic [SUM_W:0]     sum_c;
  logic [PIX_W-1:0]   mag_c;
  logic               edge_c;
  logic [PIX_W-1:0]   mag_d, mag_q;
  logic               edge_d, edge_q;
  logic               valid_q, sof_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [CNT_W-1:0]   edge_count_d, edge_count_q;
  logic               count_valid_d, count_valid_q;

  always_comb begin
    sum_c  = {1'b0, abs_q[0]} + {1'b0, abs_q[1]};
    mag_c  = side2_q.border ? '0 : sat_mag(sum_c);
    edge_c = !side2_q.border && (mag_c >= side2_q.thr);
    mag_d  = side2_q.valid ? mag_c  : mag_q;
    edge_d = side2_q.valid ? edge_c : edge_q;
  end

  // Counter is advanced from the stage-3 result so the report lines up with out_sof.
  always_comb begin
    cnt_d         = cnt_q;
    edge_count_d  = edge_count_q;
    count_valid_d = 1'b0;
    if (side2_q.valid) begin
      if (side2_q.sof) begin
        edge_count_d  = cnt_q;
        count_valid_d = 1'b1;
        cnt_d         = CNT_W'(edge_c);
      end else if (edge_c && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q         <= '0;
      edge_q        <= 1'b0;
      valid_q       <= 1'b0;
      sof_q         <= 1'b0;
      cnt_q         <= '0;
      edge_count_q  <= '0;
      count_valid_q <= 1'b0;
    end else begin
      mag_q         <= mag_d;
      edge_q        <= edge_d;
      valid_q       <= side2_q.valid;
      sof_q         <= side2_q.valid & side2_q.sof;
      cnt_q         <= cnt_d;
      edge_count_q  <= edge_count_d;
      count_valid_q <= count_valid_d;
    end
  end

  assign mag         = mag_q;
  assign edge_flag   = edge_q;
  assign out_valid   = valid_q;
  assign out_sof     = sof_q;
  assign edge_count  = edge_count_q;
  assign count_valid = count_valid_q;

endmodule

// File: tb/tb_sobel_core.sv
// Scoreboard bench for sobel_core: table vectors, frame counting,
// counter saturation, random windows and mid-stream reset.
module tb_sobel_core;

  localparam int CW = 14;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [8:0][7:0] cur_p;
  logic            in_valid, in_border, in_sof;
  logic [7:0]      thresh;
  logic [7:0]      mag;
  logic            edge_flag, out_valid, out_sof, count_valid;
  logic [CW-1:0]   edge_count;

  always #5 clk = ~clk;

  sobel_core #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_0       (cur_p[0]),
    .pix_1       (cur_p[1]),
    .pix_2       (cur_p[2]),
    .pix_3       (cur_p[3]),
    .pix_5       (cur_p[5]),
    .pix_6       (cur_p[6]),
    .pix_7       (cur_p[7]),
    .pix_8       (cur_p[8]),
    .in_valid    (in_valid),
    .in_border   (in_border),
    .in_sof      (in_sof),
    .thresh      (thresh),
    .mag         (mag),
    .edge_flag   (edge_flag),
    .out_valid   (out_valid),
    .out_sof     (out_sof),
    .edge_count  (edge_count),
    .count_valid (count_valid)
  );

  typedef struct packed {
    logic [8:0][7:0] p;
    logic            valid;
    logic            sof;
    logic            border;
    logic [7:0]      thr;
    logic [7:0]      mag;
    logic            edg;
  } vec_t;

  typedef struct {
    int            due;
    logic [7:0]    mag;
    logic          edg;
    logic          sof;
    logic          cpulse;
    logic [CW-1:0] cval;
  } exp_t;

  exp_t       sb[$];
  exp_t       got;
  vec_t       tbl[12];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         m_cnt;
  logic [7:0] m_thr;
  logic [7:0] last_mag;
  logic       last_edg;
  logic       mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0][7:0] win(input int a0, a1, a2, a3, a5, a6, a7, a8);
    logic [8:0][7:0] w;
    w = '0;
    w[0] = 8'(a0); w[1] = 8'(a1); w[2] = 8'(a2); w[3] = 8'(a3);
    w[5] = 8'(a5); w[6] = 8'(a6); w[7] = 8'(a7); w[8] = 8'(a8);
    return w;
  endfunction

  function automatic vec_t mkv(input logic [8:0][7:0] p, input logic v, s, b,
                               input int th, input int m, input logic e);
    vec_t r;
    r.p = p; r.valid = v; r.sof = s; r.border = b;
    r.thr = 8'(th); r.mag = 8'(m); r.edg = e;
    return r;
  endfunction

  function automatic logic [7:0] model_mag(input logic [8:0][7:0] p);
    int gx, gy, s;
    gx = (int'(p[2]) + 2 * int'(p[5]) + int'(p[8])) - (int'(p[0]) + 2 * int'(p[3]) + int'(p[6]));
    gy = (int'(p[6]) + 2 * int'(p[7]) + int'(p[8])) - (int'(p[0]) + 2 * int'(p[1]) + int'(p[2]));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    s = gx + gy;
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  // Drive one input cycle; when use_exp is set the table's expected values are used.
  task automatic drive(input logic [8:0][7:0] p, input logic v, s, b, input logic [7:0] th,
                       input logic use_exp, input logic [7:0] emag, input logic eedg);
    exp_t e;
    cur_p = p; in_valid = v; in_sof = s; in_border = b; thresh = th;
    if (v) begin
      if (s) m_thr = th;
      if (use_exp) begin
        e.mag = emag;
        e.edg = eedg;
      end else begin
        e.mag = b ? 8'd0 : model_mag(p);
        e.edg = !b && (e.mag >= m_thr);
      end
      e.due = cyc + 3;
      e.sof = s;
      e.cpulse = s;
      e.cval = CW'(m_cnt);
      if (s) m_cnt = int'(e.edg);
      else if (e.edg && m_cnt < CMAX) m_cnt = m_cnt + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_sof = 1'b0; in_border = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_border = 1'b0;
    sb.delete();
    m_cnt = 0; m_thr = 8'd0;
    repeat (n) begin
      @(posedge clk); #1;
    end
    last_mag = 8'd0; last_edg = 1'b0;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        n_vec++; n_err++;
        $display("FAIL missing_output: expected result due at cycle %0d not seen", sb[0].due);
        void'(sb.pop_front());
      end
      n_vec++;
      if (out_valid) begin
        if (sb.size() == 0 || sb[0].due != cyc) begin
          n_err++;
          $display("FAIL unexpected_valid: cycle %0d out_valid=1 mag=%0d, required out_valid=0", cyc, mag);
        end else begin
          got = sb.pop_front();
          if (mag !== got.mag || edge_flag !== got.edg || out_sof !== got.sof ||
              count_valid !== got.cpulse || (got.cpulse && edge_count !== got.cval)) begin
            n_err++;
            $display("FAIL pixel_out: cycle %0d got mag=%0d edge=%b sof=%b cv=%b cnt=%0d, required mag=%0d edge=%b sof=%b cv=%b cnt=%0d",
                     cyc, mag, edge_flag, out_sof, count_valid, edge_count,
                     got.mag, got.edg, got.sof, got.cpulse, got.cval);
          end
          last_mag = got.mag; last_edg = got.edg;
        end
      end else begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
          n_err++;
          $display("FAIL latency: cycle %0d out_valid=0, required out_valid=1", cyc);
          void'(sb.pop_front());
        end else if (mag !== last_mag || edge_flag !== last_edg || count_valid !== 1'b0) begin
          n_err++;
          $display("FAIL hold: cycle %0d got mag=%0d edge=%b cv=%b, required mag=%0d edge=%b cv=0",
                   cyc, mag, edge_flag, count_valid, last_mag, last_edg);
        end
      end
    end
  end

  initial begin
    logic [8:0][7:0] uni, vert, vswp, smal;
    int wait_cnt;
    uni  = win(100, 100, 100, 100, 100, 100, 100, 100);
    vert = win(0, 128, 255, 0, 255, 0, 128, 255);
    vswp = win(255, 128, 0, 255, 0, 255, 128, 0);
    smal = win(0, 5, 10, 0, 10, 0, 5, 10);

    tbl[0]  = mkv(uni,  1, 1, 0, 1,   0,   0);
    tbl[1]  = mkv(vert, 1, 1, 0, 128, 255, 1);
    tbl[2]  = mkv(vswp, 1, 0, 0, 0,   255, 1);
    tbl[3]  = mkv(uni,  0, 0, 0, 0,   0,   0);
    tbl[4]  = mkv(smal, 1, 1, 0, 40,  40,  1);
    tbl[5]  = mkv(smal, 1, 1, 0, 41,  40,  0);
    tbl[6]  = mkv(smal, 1, 0, 0, 0,   40,  0);
    tbl[7]  = mkv(vert, 1, 0, 1, 0,   0,   0);
    tbl[8]  = mkv(win(0, 0, 0, 0, 0, 0, 50, 0),    1, 0, 0, 0, 100, 1);
    tbl[9]  = mkv(win(0, 50, 0, 0, 0, 0, 0, 0),    1, 0, 0, 0, 100, 1);
    tbl[10] = mkv(win(0, 0, 60, 0, 60, 0, 10, 60), 1, 0, 0, 0, 255, 1);
    tbl[11] = mkv(win(0, 0, 60, 0, 60, 0, 7, 60),  1, 0, 0, 0, 254, 1);

    cur_p = '0; in_valid = 1'b0; in_sof = 1'b0; in_border = 1'b0; thresh = 8'd0;
    do_reset(3);

    // Reset state
    n_vec++;
    if (mag !== 8'd0 || edge_flag !== 1'b0 || out_valid !== 1'b0 || out_sof !== 1'b0 ||
        edge_count !== '0 || count_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: mag=%0d edge=%b ov=%b sof=%b cnt=%0d cv=%b, required all 0",
               mag, edge_flag, out_valid, out_sof, edge_count, count_valid);
    end
    mon_en = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].p, tbl[i].valid, tbl[i].sof, tbl[i].border, tbl[i].thr,
            1'b1, tbl[i].mag, tbl[i].edg);
    end
    idle(5);

    // Frame A: 5 pixels, 3 edges at threshold 100, bubbles in between
    drive(vert, 1, 1, 0, 8'd100, 0, 0, 0);
    idle(1);
    drive(uni,  1, 0, 0, 8'd0, 0, 0, 0);
    idle(2);
    drive(vert, 1, 0, 0, 8'd0, 0, 0, 0);
    idle(1);
    drive(smal, 1, 0, 0, 8'd0, 0, 0, 0);
    drive(vswp, 1, 0, 0, 8'd0, 0, 0, 0);
    drive(uni,  1, 1, 0, 8'd1, 0, 0, 0);
    idle(5);

    // Counter saturation: more edge pixels than the counter can hold
    drive(vert, 1, 1, 0, 8'd128, 0, 0, 0);
    for (int i = 0; i < CMAX + 20; i++) drive(vert, 1, 0, 0, 8'd0, 0, 0, 0);
    drive(vswp, 1, 1, 0, 8'd200, 0, 0, 0);
    idle(5);

    // Random windows
    for (int i = 0; i < 40; i++) begin
      drive(win($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255)),
            1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 9) == 0), 8'($urandom_range(0, 255)), 0, 0, 0);
    end
    idle(5);

    // Mid-stream reset: a pixel accepted one cycle before reset must vanish
    drive(vert, 1, 1, 0, 8'd10, 0, 0, 0);
    do_reset(1);
    idle(6);
    n_vec++;
    if (edge_count !== '0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midstream: edge_count=%0d out_valid=%b, required 0 and 0", edge_count, out_valid);
    end

    // First sof after reset reports a count of 0 again
    drive(vert, 1, 1, 0, 8'd50, 0, 0, 0);
    drive(vert, 1, 0, 0, 8'd0, 0, 0, 0);
    drive(uni,  1, 1, 0, 8'd0, 0, 0, 0);

    wait_cnt = 0;
    in_valid = 1'b0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    if (sb.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
    idle(2);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
